serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 156 +++++++++++++++
 tb/tb_serial_subtractor.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor D = A - B - bin (mod 2^WIDTH), DIGIT bits per cycle, valid/ready on both sides.
// Optional signed-overflow output is built only when SERIAL_SUB_OVF_EN is defined; otherwise ovf is tied low.
module serial_subtractor #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;

  logic             accept;
  logic             cnt_done;
  logic             finish;
  logic [DIGIT:0]   br_chain;
  logic [DIGIT-1:0] slice_diff;

  assign accept   = (state_q == IDLE) && in_valid;
  assign cnt_done = (cnt_q == CW'(NDIG));
  assign finish   = (state_q == RUN) && cnt_done;

  // Borrow-ripple slice over the low DIGIT bits of the operand shift registers.
  assign br_chain[0] = br_q;
  for (genvar i = 0; i < DIGIT; i++) begin : g_slice
    assign slice_diff[i]  = a_sh_q[i] ^ b_sh_q[i] ^ br_chain[i];
    assign br_chain[i+1]  = (~a_sh_q[i] & b_sh_q[i]) |
                            (~(a_sh_q[i] ^ b_sh_q[i]) & br_chain[i]);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    br_d    = br_q;
    res_d   = res_q;
    d_d     = d_q;
    bout_d  = bout_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_done) begin
          // Outputs are only updated here so they stay frozen through DONE and IDLE.
          d_d     = res_q;
          bout_d  = br_q;
          state_d = DONE;
        end else begin
          a_sh_d = a_sh_q >> DIGIT;
          b_sh_d = b_sh_q >> DIGIT;
          br_d   = br_chain[DIGIT];
          res_d  = (res_q >> DIGIT) | (WIDTH'(slice_diff) << (WIDTH - DIGIT));
          cnt_d  = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      br_q    <= 1'b0;
      res_q   <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      br_q    <= br_d;
      res_q   <= res_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign d         = d_q;
  assign bout      = bout_q;

`ifdef SERIAL_SUB_OVF_EN
  // Operand sign bits are captured at accept because the shift registers lose them.
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;

  always_comb begin
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
    if (accept) begin
      a_msb_d = a[WIDTH-1];
      b_msb_d = b[WIDTH-1];
    end
    if (finish) begin
      ovf_d = (a_msb_q != b_msb_q) && (res_q[WIDTH-1] != a_msb_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized self-checking bench for serial_subtractor against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int LAT   = WIDTH / DIGIT + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             ovf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout),
    .ovf       (ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic.
  function automatic logic [WIDTH-1:0] ref_d(input logic [WIDTH-1:0] av, bv, input logic bi);
    longint diff;
    diff = longint'(av) - longint'(bv) - longint'(bi);
    diff = (diff + (longint'(1) << WIDTH)) % (longint'(1) << WIDTH);
    return WIDTH'(diff);
  endfunction

  function automatic logic ref_bout(input logic [WIDTH-1:0] av, bv, input logic bi);
    return longint'(av) < (longint'(bv) + longint'(bi));
  endfunction

  function automatic logic ref_ovf(input logic [WIDTH-1:0] av, bv, input logic bi);
`ifdef SERIAL_SUB_OVF_EN
    longint sres;
    sres = longint'($signed(av)) - longint'($signed(bv)) - longint'(bi);
    return (sres > ((longint'(1) << (WIDTH - 1)) - 1)) || (sres < -(longint'(1) << (WIDTH - 1)));
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int cyc;
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      tick();
      cyc++;
    end
    check("in_ready_wait", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic bi,
                        input int hold, input bit poke);
    int cyc;
    logic [WIDTH-1:0] ed;
    logic eb, eo;
    ed = ref_d(av, bv, bi);
    eb = ref_bout(av, bv, bi);
    eo = ref_ovf(av, bv, bi);
    wait_ready();
    a = av; b = bv; bin = bi; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
    check("in_ready_drop", {31'd0, in_ready}, 32'd0);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      in_valid = poke && (cyc == 1);
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    check("latency", cyc, LAT);
    check("d", {16'd0, d}, {16'd0, ed});
    check("bout", {31'd0, bout}, {31'd0, eb});
    check("ovf", {31'd0, ovf}, {31'd0, eo});
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("hold_d", {16'd0, d}, {16'd0, ed});
      check("hold_bout", {31'd0, bout}, {31'd0, eb});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("in_ready_after", {31'd0, in_ready}, 32'd1);
    check("out_valid_after", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b0;
    repeat (2) tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_d", {16'd0, d}, 32'd0);
    check("rst_bout", {31'd0, bout}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    rst = 1'b0;
    tick();

    run_op(16'h1234, 16'h0234, 1'b0, 0, 1'b0);
    check("t1_d", {16'd0, d}, 32'h1000);
    run_op(16'h0000, 16'h0001, 1'b0, 0, 1'b0);
    check("t2_d", {16'd0, d}, 32'hFFFF);
    check("t2_bout", {31'd0, bout}, 32'd1);
    check("t2_ovf", {31'd0, ovf}, 32'd0);
    run_op(16'h0005, 16'h0005, 1'b1, 0, 1'b0);
    check("t3a_d", {16'd0, d}, 32'hFFFF);
    run_op(16'hFFFF, 16'h0000, 1'b1, 0, 1'b0);
    check("t3b_d", {16'd0, d}, 32'hFFFE);
    check("t3b_bout", {31'd0, bout}, 32'd0);
    run_op(16'h8000, 16'h0001, 1'b0, 0, 1'b0);
    check("t4_d", {16'd0, d}, 32'h7FFF);
`ifdef SERIAL_SUB_OVF_EN
    check("t4_ovf", {31'd0, ovf}, 32'd1);
`else
    check("t4_ovf", {31'd0, ovf}, 32'd0);
`endif

    // Backpressure plus an in_valid pulse during RUN that must be ignored.
    run_op(16'hABCD, 16'h1357, 1'b1, 3, 1'b1);

    // Asynchronous reset two cycles into RUN.
    wait_ready();
    a = 16'h4321; b = 16'h0123; bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_d", {16'd0, d}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    run_op(16'h00FF, 16'h000F, 1'b0, 0, 1'b0);
    check("t6_d", {16'd0, d}, 32'h00F0);

    for (int n = 0; n < 40; n++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
